// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency, single-port memory between the
// instruction-fetch port and the data (load/store) port.
// Each transaction walks IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Every output is driven from a register.
// Optional build macro MEM_ARB_RR_EN selects round-robin arbitration.
// Without it, the data port has fixed priority.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              arb_busy
);

    // Latency fits in four bits (legal range 1..15)
    localparam logic [3:0] LAT = 4'(MEM_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       owner_dm;
    logic       grant_dm;

`ifdef MEM_ARB_RR_EN
    logic last_dm;

    // On contention, grant the port that was not served last
    always_comb grant_dm = dm_req && (!if_req || !last_dm);
`else
    // Fixed priority: data port wins whenever it requests
    always_comb grant_dm = dm_req;
`endif

    // Arbiter FSM: grant capture, memory strobe, latency count, ack pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            owner_dm  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            arb_busy  <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_dm   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || dm_req) begin
                        state     <= ISSUE;
                        mem_en    <= 1'b1;
                        arb_busy  <= 1'b1;
                        owner_dm  <= grant_dm;
                        mem_addr  <= grant_dm ? dm_addr : if_addr;
                        mem_wdata <= grant_dm ? dm_wdata : '0;
                        mem_we    <= grant_dm && dm_we;
`ifdef MEM_ARB_RR_EN
                        last_dm   <= grant_dm;
`endif
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    cnt    <= LAT;
                    state  <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        // Read data is valid in this cycle; writes leave rdata untouched
                        if (!mem_we) begin
                            if (owner_dm) dm_rdata <= mem_rdata;
                            else          if_rdata <= mem_rdata;
                        end
                        dm_ack <= owner_dm;
                        if_ack <= !owner_dm;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    if_ack   <= 1'b0;
                    dm_ack   <= 1'b0;
                    arb_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios, then randomized transactions.
// Expected values come from a memory model and from the arbitration rules.
module tb_mem_arbiter;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ack, dm_ack, mem_en, mem_we, arb_busy;

  // Second instance exercises the single-cycle latency corner
  logic        if_req1, dm_req1, dm_we1;
  logic [31:0] if_addr1, dm_addr1, dm_wdata1, mem_rdata1;
  logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1;
  logic        if_ack1, dm_ack1, mem_en1, mem_we1, arb_busy1;

  int checks = 0;
  int failures = 0;

  logic [31:0] memarr    [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] exp_if, exp_dm;
  bit          last_dm;
  logic [3:0]  obs_grants;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .arb_busy(arb_busy)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ack(if_ack1),
    .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
    .dm_rdata(dm_rdata1), .dm_ack(dm_ack1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .arb_busy(arb_busy1)
  );

  function automatic logic [31:0] hash(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : hash(a);
  endfunction

  // Memory for the main instance: read data valid only LAT cycles after mem_en
  initial begin
    int          cd;
    logic [31:0] rd;
    cd = 0;
    rd = '0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_rdata = $urandom;
      if (cd > 0) begin
        cd--;
        if (cd == 0) mem_rdata = rd;
      end
      if (mem_en === 1'b1) begin
        if (mem_we === 1'b1) memarr[mem_addr] = mem_wdata;
        else begin
          rd = memarr.exists(mem_addr) ? memarr[mem_addr] : hash(mem_addr);
          cd = LAT;
        end
      end
    end
  end

  // Memory for the latency-1 instance
  initial begin
    bit pend;
    pend = 1'b0;
    mem_rdata1 = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_rdata1 = pend ? 32'hCAFE_0001 : $urandom;
      pend = (mem_en1 === 1'b1) && (mem_we1 !== 1'b1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_if  = '0;
    exp_dm  = '0;
    last_dm = 1'b0;
  endtask

  // Presents requests in an IDLE cycle and follows the transaction to the next IDLE
  task automatic txn(input bit ireq, input bit dreq, input bit dwe,
                     input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                     input bit keep_if, input bit keep_dm);
    bit          win_dm, we;
    logic [31:0] a, rd;
    if_req = ireq; dm_req = dreq; dm_we = dwe;
    if_addr = ia; dm_addr = da; dm_wdata = wd;
    if (ireq && dreq) begin
`ifdef MEM_ARB_RR_EN
      win_dm = !last_dm;
`else
      win_dm = 1'b1;
`endif
    end else begin
      win_dm = dreq;
    end
    last_dm = win_dm;
    a  = win_dm ? da : ia;
    we = win_dm && dwe;
    rd = model_read(a);
    if (we) model_mem[a] = wd;
    else if (win_dm) exp_dm = rd;
    else exp_if = rd;

    step();
    chk("issue_en", mem_en, 1);
    chk("issue_addr", mem_addr, a);
    chk("issue_we", mem_we, we);
    if (we) chk("issue_wdata", mem_wdata, wd);
    chk("issue_busy", arb_busy, 1);
    chk("issue_acks", {if_ack, dm_ack}, 0);
    for (int i = 0; i < LAT; i++) begin
      step();
      chk("wait_en", mem_en, 0);
      chk("wait_addr", mem_addr, a);
      chk("wait_acks", {if_ack, dm_ack}, 0);
      chk("wait_busy", arb_busy, 1);
    end
    step();
    chk("ack_if", if_ack, !win_dm);
    chk("ack_dm", dm_ack, win_dm);
    chk("if_rdata", if_rdata, exp_if);
    chk("dm_rdata", dm_rdata, exp_dm);
    chk("resp_busy", arb_busy, 1);
    obs_grants = {obs_grants[2:0], dm_ack};
    if (!keep_if) if_req = 1'b0;
    if (!keep_dm) dm_req = 1'b0;
    step();
    chk("idle_busy", arb_busy, 0);
    chk("idle_acks", {if_ack, dm_ack}, 0);
    chk("idle_en", mem_en, 0);
  endtask

  initial begin
    logic [3:0]  exp_order;
    logic [31:0] ra, rb;
    bit          ri, rd_, rw;
    int          gap;

    rst = 1'b1;
    if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    if_req1 = 0; dm_req1 = 0; dm_we1 = 0;
    if_addr1 = '0; dm_addr1 = '0; dm_wdata1 = '0;
    obs_grants = '0;
    model_reset();
    memarr[32'h40]    = 32'h2002_0005;
    model_mem[32'h40] = 32'h2002_0005;

    step();
    step();
    chk("rst_busy", arb_busy, 0);
    chk("rst_en", mem_en, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_acks", {if_ack, dm_ack}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    rst = 1'b0;
    step();

    // Fetch-only read of the preloaded word
    txn(1, 0, 0, 32'h40, 32'h0, 32'h0, 0, 0);
    chk("fetch_word", if_rdata, 32'h2002_0005);

    // Data read, then a write that must not disturb dm_rdata, then read-back
    txn(0, 1, 0, 32'h0, 32'h200, 32'h0, 0, 0);
    txn(0, 1, 1, 32'h0, 32'h100, 32'hDEAD_BEEF, 0, 0);
    chk("write_hold_rdata", dm_rdata, hash(32'h200));
    txn(0, 1, 0, 32'h0, 32'h100, 32'h0, 0, 0);
    chk("readback", dm_rdata, 32'hDEAD_BEEF);

    // Simultaneous requests; fetch keeps requesting after the first ack
    txn(1, 1, 0, 32'h44, 32'h104, 32'h0, 1, 0);
    txn(1, 0, 0, 32'h44, 32'h0, 32'h0, 0, 0);

    // Reset during WAIT of a data read
    if_req = 0; dm_req = 1; dm_we = 0; dm_addr = 32'h108;
    step();
    chk("pre_rst_en", mem_en, 1);
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", arb_busy, 0);
    chk("mid_rst_en", mem_en, 0);
    chk("mid_rst_acks", {if_ack, dm_ack}, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_dm_rdata", dm_rdata, 0);
    chk("mid_rst_if_rdata", if_rdata, 0);
    model_reset();
    step();
    chk("rst_hold_acks", {if_ack, dm_ack}, 0);
    chk("rst_hold_busy", arb_busy, 0);
    rst = 1'b0;
    txn(0, 1, 0, 32'h0, 32'h108, 32'h0, 0, 0);

    // Clean reset, then both ports hold requests for four transactions
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    step();
    obs_grants = '0;
    for (int k = 0; k < 4; k++) begin
      txn(1, 1, 0, 32'h80 + 32'(k * 4), 32'h180 + 32'(k * 4), 32'h0, k < 3, k < 3);
    end
`ifdef MEM_ARB_RR_EN
    exp_order = 4'b1010;
`else
    exp_order = 4'b1111;
`endif
    chk("grant_order", obs_grants, exp_order);

    // Latency-1 instance: fetch read
    if_req1 = 1'b1; if_addr1 = 32'h0000_0080;
    step();
    chk("l1_issue_en", mem_en1, 1);
    chk("l1_issue_addr", mem_addr1, 32'h80);
    step();
    chk("l1_wait_ack", if_ack1, 0);
    chk("l1_wait_en", mem_en1, 0);
    step();
    chk("l1_ack", if_ack1, 1);
    chk("l1_rdata", if_rdata1, 32'hCAFE_0001);
    chk("l1_dm_ack", dm_ack1, 0);
    if_req1 = 1'b0;
    step();
    chk("l1_idle_ack", if_ack1, 0);
    chk("l1_idle_busy", arb_busy1, 0);

    // Randomized traffic over a small address window so writes get read back
    for (int n = 0; n < 40; n++) begin
      ri  = 1'($urandom_range(0, 1));
      rd_ = 1'($urandom_range(0, 1));
      if (!ri && !rd_) ri = 1'b1;
      rw  = 1'($urandom_range(0, 1));
      ra  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      rb  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      txn(ri, rd_, rw, ra, rb, $urandom, 0, 0);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        step();
        chk("gap_busy", arb_busy, 0);
        chk("gap_en", mem_en, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the CPU's single-port unified memory between the instruction-fetch port and the data (load/store) port. It sits between the `cpu` datapath and the memory model and sequences every access through one fixed-latency memory interface. It registers the winning request, issues a one-cycle memory strobe, waits out the memory latency, and returns the read data with a one-cycle acknowledge.

## Interface
Parameters:
- `ADDR_W`, default 32: address width, passed through unchanged to `mem_addr`.
- `DATA_W`, default 32: data width.
- `MEM_LAT`, default 2: memory read latency in cycles. Legal range is 1 to 15.

Ports:
- `clk` input 1: the single clock. All state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `if_req` input 1: instruction-fetch request (read only).
- `if_addr` input ADDR_W: fetch address.
- `if_rdata` output DATA_W: fetched instruction, valid while `if_ack` is high.
- `if_ack` output 1: one-cycle completion pulse for the fetch port.
- `dm_req` input 1: data-port request.
- `dm_we` input 1: data-port direction. 1 = write, 0 = read.
- `dm_addr` input ADDR_W: data address.
- `dm_wdata` input DATA_W: store data.
- `dm_rdata` output DATA_W: load data, valid while `dm_ack` is high.
- `dm_ack` output 1: one-cycle completion pulse for the data port.
- `mem_en` output 1: memory access strobe, high for exactly one cycle per transaction.
- `mem_we` output 1: memory write enable, qualified by `mem_en`.
- `mem_addr` output ADDR_W: memory address.
- `mem_wdata` output DATA_W: memory write data.
- `mem_rdata` input DATA_W: memory read data, valid exactly MEM_LAT cycles after the `mem_en` cycle.
- `arb_busy` output 1: high in every state except IDLE.

## Operation
- FSM states:
  - IDLE: arbitrates among requests present in this cycle. If any request is present, go to ISSUE; otherwise stay in IDLE.
  - ISSUE: `mem_en` = 1. Load the counter with MEM_LAT, then go to WAIT.
  - WAIT: decrement the counter each cycle. On the cycle the counter reaches 1, capture `mem_rdata` into the owner's rdata register, then go to RESP.
  - RESP: the owner's ack = 1, then go to IDLE.
- Grant capture: on the IDLE→ISSUE edge, register the owner, the address, the write data and the write enable. The `mem_*` outputs come from these registers, so they stay stable whatever the requesters do afterwards.
- Fetch port: always a read. `mem_we` = 0 for fetch transactions.
- Data writes: take the same path and ack at the same point. `dm_rdata` is not updated on writes and holds its previous value.
- Request protocol:
  - `req` is a level signal. A high `req` sampled in IDLE is a new request.
  - A requester that wants no further transaction deasserts `req` on the edge ending its ack cycle.
  - A requester that keeps `req` high past its ack issues a new request, using whatever address is present in that IDLE cycle.
- `req` dropped mid-transaction is a protocol violation. The transaction completes regardless and the ack still pulses.
- Only one ack is ever high in a given cycle. The non-owner's ack is never asserted.
- Reset, whether at power-up or mid-transaction:
  - State goes to IDLE immediately.
  - `mem_en`, `mem_we`, `if_ack`, `dm_ack` and `arb_busy` go to 0.
  - `mem_addr`, `mem_wdata`, `if_rdata` and `dm_rdata` go to 0.
  - The counter is cleared and the round-robin pointer is set to "fetch last served".
  - An aborted transaction is never acked, and its request must be re-sampled after reset.

## Timing
- Request sampled in IDLE at cycle r. ISSUE (`mem_en`) occurs at r+1. Read data is captured at the end of cycle r+1+MEM_LAT. Ack occurs at r+2+MEM_LAT.
- Request-to-ack latency is MEM_LAT+2 cycles. Back-to-back transactions take MEM_LAT+3 cycles each, because IDLE is always visited once.
- Outputs are registered. There is no combinational path from any input to any output.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - When both ports request in the same IDLE cycle, grant the port that was not served last.
  - The pointer updates on every grant.
  - The first contention after reset goes to the data port.
- `MEM_ARB_RR_EN` undefined: fixed priority.
  - The data port always wins contention.
  - The fetch port is granted only in an IDLE cycle with `dm_req` = 0.
  - The pointer logic is absent.

## Test plan
All scenarios use MEM_LAT=2 unless stated.
- Fetch-only read, `if_addr`=0x0000_0040, memory returns 0x2002_0005 → `mem_en`=1, `mem_we`=0, `mem_addr`=0x40 at r+1. `if_ack`=1 with `if_rdata`=0x2002_0005 at r+4 only. `dm_ack` stays 0 throughout.
- Data write, `dm_addr`=0x100, `dm_wdata`=0xDEAD_BEEF → at r+1, `mem_we`=1 and `mem_wdata`=0xDEAD_BEEF. `dm_ack` at r+4. `dm_rdata` unchanged from its prior value.
- `if_req` and `dm_req` both rise at r, with `MEM_LAT=2` and the macro undefined → data ISSUE at r+1 and `dm_ack` at r+4. Fetch ISSUE at r+6 and `if_ack` at r+9. The fetch address is not presented to memory before r+6.
- Both requests held high for 4 transactions:
  - With `MEM_ARB_RR_EN` defined, the grant order is D,I,D,I.
  - With the macro undefined, the grant order is D,D,D,D and `if_ack` never pulses.
- `rst` asserted at r+2, during WAIT of a data read → `arb_busy`, `mem_en` and both acks read 0 before the next edge. No `dm_ack` occurs. After `rst` drops with `dm_req` high, a fresh ISSUE occurs and `dm_ack` arrives MEM_LAT+2 cycles after the first IDLE sample.
- `MEM_LAT`=1, fetch read → `mem_en` at r+1, data captured at the end of r+2, `if_ack` at r+3.
